// File: rtl/toy_fetch_sink.sv
// Exec-side sink for the fetch->exec stream: {pc,inst} FIFO plus a tracker for the single
// in-flight jump that drives the fetch redirect/unlock pulses. Optional TOY_FETCH_SINK_STATS_EN adds jump/taken counters.
module toy_fetch_sink #(
   parameter int ADDR_WIDTH = 32,
   parameter int INST_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  instruction_vld,
   output logic                  instruction_rdy,
   input  logic [INST_WIDTH-1:0] instruction_pld,
   input  logic [ADDR_WIDTH-1:0] instruction_pc,
   output logic                  issue_vld,
   input  logic                  issue_rdy,
   output logic [INST_WIDTH-1:0] issue_pld,
   output logic [ADDR_WIDTH-1:0] issue_pc,
   input  logic                  resolve_vld,
   input  logic                  resolve_taken,
   input  logic [ADDR_WIDTH-1:0] resolve_target,
   output logic                  pc_update_en,
   output logic [ADDR_WIDTH-1:0] pc_val,
   output logic                  pc_release_en,
   output logic                  proto_err
`ifdef TOY_FETCH_SINK_STATS_EN
   ,
   output logic [31:0]           jump_cnt,
   output logic [31:0]           taken_cnt
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   // Both channels are valid/ready: a beat transfers on the rising clk edge where valid && ready;
   // valid must not depend on ready, and ready here never depends on the peer's valid.
   typedef enum logic [1:0] {RUN, HELD, WAIT_RES, REL} state_t;
   state_t state_q, state_d;

   logic [INST_WIDTH-1:0] mem_inst [DEPTH];
   logic [ADDR_WIDTH-1:0] mem_pc   [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]      count_q;
   logic [ADDR_WIDTH-1:0] jump_pc_q;
   logic                  push, pop, is_jump, resolve_fire, proto_viol;
   logic [4:0]            opcode;

   assign opcode          = instruction_pld[6:2];
   assign is_jump         = (opcode == 5'b11011) || (opcode == 5'b11001) || (opcode == 5'b11000);
   assign instruction_rdy = (count_q < FULL_CNT) && (state_q == RUN);
   assign issue_vld       = (count_q != '0);
   assign issue_pld       = mem_inst[rd_ptr_q];
   assign issue_pc        = mem_pc[rd_ptr_q];
   assign push            = instruction_vld && instruction_rdy;
   assign pop             = issue_vld && issue_rdy;
   assign resolve_fire    = resolve_vld && (state_q == WAIT_RES);
   assign proto_viol      = (resolve_vld && (state_q != WAIT_RES)) ||
                            (instruction_vld && (state_q != RUN));

   always_ff @(posedge clk) begin
      if (push) begin
         mem_inst[wr_ptr_q] <= instruction_pld;
         mem_pc[wr_ptr_q]   <= instruction_pc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= RUN;
      else        state_q <= state_d;
   end

   // Fetch stalls after a jump, so the jump is the youngest entry: its pop empties the FIFO.
   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:      if (push && is_jump) state_d = HELD;
         HELD:     if (pop && (count_q == CNT_W'(1))) state_d = WAIT_RES;
         WAIT_RES: if (resolve_vld) state_d = REL;
         REL:      state_d = RUN;
         default:  state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_update_en  <= 1'b0;
         pc_release_en <= 1'b0;
         pc_val        <= '0;
         jump_pc_q     <= '0;
         proto_err     <= 1'b0;
      end else begin
         pc_update_en  <= 1'b0;
         pc_release_en <= 1'b0;
         if (resolve_fire) begin
            pc_release_en <= 1'b1;
            pc_update_en  <= resolve_taken;
            pc_val        <= resolve_taken ? resolve_target : jump_pc_q + ADDR_WIDTH'(4);
         end
         if (push && is_jump) jump_pc_q <= instruction_pc;
         if (proto_viol)      proto_err <= 1'b1;
      end
   end

`ifdef TOY_FETCH_SINK_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         jump_cnt  <= '0;
         taken_cnt <= '0;
      end else if (resolve_fire) begin
         jump_cnt <= jump_cnt + 32'd1;
         if (resolve_taken) taken_cnt <= taken_cnt + 32'd1;
      end
   end
`endif

endmodule
